// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures high time and period of an async PWM input and
// reports floor(high*100/period). Optional PWM_GLITCH_FILTER_EN adds a 4-cycle stability filter.
module pwm_duty_meter #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [6:0]       duty_pct,
  output logic             valid,
  output logic             stuck
);

  localparam int unsigned NUM_W  = CNT_W + 7;
  localparam int unsigned ITER_W = $clog2(NUM_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [0:0] WAIT_EDGE = 1'b0;
  localparam logic [0:0] MEASURE   = 1'b1;

  logic             sync_q1, s, lvl, lvl_d, rise;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
  logic             capture, timeout;

  logic              div_busy;
  logic [ITER_W-1:0] iter_q;
  logic [NUM_W-1:0]  num_q, quo_nx;
  logic [CNT_W-1:0]  rem_q, rem_nx, den_q, hcap_q;
  logic [CNT_W:0]    rem_sh;
  logic              ge, last_iter, div_idle;
  logic [6:0]        duty_sat;

  // Input synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      s       <= 1'b0;
    end else begin
      sync_q1 <= pwm_in;
      s       <= sync_q1;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  logic [1:0] stab_cnt;
  logic       filt;

  // Level follows s only after s has disagreed with it for 4 consecutive cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= 2'd0;
      filt     <= 1'b0;
    end else if (s == filt) begin
      stab_cnt <= 2'd0;
    end else if (stab_cnt == 2'd3) begin
      stab_cnt <= 2'd0;
      filt     <= s;
    end else begin
      stab_cnt <= stab_cnt + 2'd1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = s;
`endif

  assign rise = lvl & ~lvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_d   <= 1'b0;
      state_q <= WAIT_EDGE;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
    end else begin
      lvl_d   <= lvl;
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Measurement FSM: a rise closes one period and opens the next in the same cycle
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    hcnt_d  = hcnt_q;
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      WAIT_EDGE: begin
        pcnt_d = '0;
        hcnt_d = '0;
        if (rise) begin
          state_d = MEASURE;
          pcnt_d  = CNT_W'(1);
          hcnt_d  = CNT_W'(1);
        end
      end
      MEASURE: begin
        if (rise) begin
          capture = 1'b1;
          pcnt_d  = CNT_W'(1);
          hcnt_d  = CNT_W'(1);
        end else if (pcnt_q == CNT_MAX) begin
          timeout = 1'b1;
          state_d = WAIT_EDGE;
          pcnt_d  = '0;
          hcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + CNT_W'(1);
          hcnt_d = hcnt_q + CNT_W'(lvl);
        end
      end
      default: state_d = WAIT_EDGE;
    endcase
  end

  // One restoring step: numerator bits shift out of num_q while quotient bits shift in
  assign rem_sh    = {rem_q, num_q[NUM_W-1]};
  assign ge        = rem_sh >= {1'b0, den_q};
  assign rem_nx    = ge ? CNT_W'(rem_sh - {1'b0, den_q}) : rem_sh[CNT_W-1:0];
  assign quo_nx    = {num_q[NUM_W-2:0], ge};
  assign duty_sat  = (quo_nx > NUM_W'(100)) ? 7'd100 : quo_nx[6:0];
  assign last_iter = div_busy && (iter_q == ITER_W'(1));
  // The output-update cycle still counts as busy, so a capture there is dropped
  assign div_idle  = !div_busy && !valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_busy <= 1'b0;
      iter_q   <= '0;
      num_q    <= '0;
      rem_q    <= '0;
      den_q    <= '0;
      hcap_q   <= '0;
    end else if (timeout) begin
      div_busy <= 1'b0;
      iter_q   <= '0;
    end else if (capture && div_idle) begin
      div_busy <= 1'b1;
      iter_q   <= ITER_W'(NUM_W);
      num_q    <= NUM_W'(hcnt_q) * NUM_W'(100);
      rem_q    <= '0;
      den_q    <= pcnt_q;
      hcap_q   <= hcnt_q;
    end else if (div_busy) begin
      num_q  <= quo_nx;
      rem_q  <= rem_nx;
      iter_q <= iter_q - ITER_W'(1);
      if (last_iter) div_busy <= 1'b0;
    end
  end

  // Result registers; timeout report overrides a divide in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      duty_pct   <= 7'd0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (timeout) begin
        high_cnt   <= '0;
        period_cnt <= '0;
        duty_pct   <= lvl ? 7'd100 : 7'd0;
        stuck      <= 1'b1;
        valid      <= 1'b1;
      end else if (last_iter) begin
        high_cnt   <= hcap_q;
        period_cnt <= den_q;
        duty_pct   <= duty_sat;
        stuck      <= 1'b0;
        valid      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: default-width instance for duty/latency,
// a CNT_W=10 instance for the timeout path.
module tb_pwm_duty_meter;

`ifdef PWM_GLITCH_FILTER_EN
  localparam int LAT    = 34;
  localparam int LAT10  = 24;
  localparam int TO_LAT = 1030;
`else
  localparam int LAT    = 30;
  localparam int LAT10  = 20;
  localparam int TO_LAT = 1026;
`endif
  localparam int MINP = 29;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_a = 1'b0;
  logic        pwm_b = 1'b0;
  logic [19:0] high_a, period_a;
  logic [9:0]  high_b, period_b;
  logic [6:0]  duty_a, duty_b;
  logic        valid_a, valid_b, stuck_a, stuck_b;

  pwm_duty_meter u_dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_a),
    .high_cnt(high_a), .period_cnt(period_a), .duty_pct(duty_a),
    .valid(valid_a), .stuck(stuck_a)
  );

  pwm_duty_meter #(.CNT_W(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_b),
    .high_cnt(high_b), .period_cnt(period_b), .duty_pct(duty_b),
    .valid(valid_b), .stuck(stuck_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int h;
    int p;
    int d;
    int st;
  } rec_t;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  rec_t vq[$];
  rec_t vq10[$];
  int   rq[$];

  // Log every valid pulse with its cycle stamp
  initial begin
    rec_t r;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid_a) begin
        r.t = cyc; r.h = int'(high_a); r.p = int'(period_a);
        r.d = int'(duty_a); r.st = int'(stuck_a);
        vq.push_back(r);
      end
      if (valid_b) begin
        r.t = cyc; r.h = int'(high_b); r.p = int'(period_b);
        r.d = int'(duty_b); r.st = int'(stuck_b);
        vq10.push_back(r);
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pwm_a = 1'b0;
    pwm_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // n periods of (h,p) plus a closing rise, then compare valids against launch model
  task automatic seg(input int h, input int p, input int n, input int d, input string tag);
    int last;
    int idx;
    rq.delete();
    vq.delete();
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < p; j++) begin
        @(negedge clk);
        pwm_a = (j < h);
        if (j == 0) rq.push_back(cyc);
      end
    end
    for (int j = 0; j < h + LAT + 15; j++) begin
      @(negedge clk);
      pwm_a = (j < h);
      if (j == 0) rq.push_back(cyc);
    end
    last = -1000;
    idx  = 0;
    for (int k = 1; k < rq.size(); k++) begin
      if (rq[k] - last >= MINP) begin
        last = rq[k];
        if (idx < vq.size()) begin
          check({tag, "_t"},  vq[idx].t,  rq[k] + LAT);
          check({tag, "_h"},  vq[idx].h,  h);
          check({tag, "_p"},  vq[idx].p,  p);
          check({tag, "_d"},  vq[idx].d,  d);
          check({tag, "_st"}, vq[idx].st, 0);
        end
        idx++;
      end
    end
    check({tag, "_cnt"}, vq.size(), idx);
  endtask

  initial begin
    int n;
    int r0;
    int r1;
    int ts[4];
    int et[$];
    int eh[$];
    int ep[$];
    int ed[$];

    do_reset();
    #1;
    check("rst_high", int'(high_a), 0);
    check("rst_period", int'(period_a), 0);
    check("rst_duty", int'(duty_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_stuck", int'(stuck_a), 0);

    seg(250, 1000, 3, 25, "d25");
    do_reset();
    seg(10, 20, 8, 50, "short20");
`ifndef PWM_GLITCH_FILTER_EN
    do_reset();
    seg(1, 3, 30, 33, "d33");
    do_reset();
    seg(999, 1000, 2, 99, "d99");
    do_reset();
    seg(39, 40, 4, 97, "d97");
`endif

    // Reset in the middle of a divide
    do_reset();
    vq.delete();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 1000; j++) begin
        @(negedge clk);
        pwm_a = (j < 250);
      end
    @(negedge clk);
    pwm_a = 1'b1;
    repeat (10) @(negedge clk);
    check("pre_rst_duty", int'(duty_a), 25);
    rst_n = 1'b0;
    pwm_a = 1'b0;
    #1;
    check("mid_rst_high", int'(high_a), 0);
    check("mid_rst_period", int'(period_a), 0);
    check("mid_rst_duty", int'(duty_a), 0);
    check("mid_rst_valid", int'(valid_a), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vq.delete();
    repeat (40) @(negedge clk);
    check("stale_valid", vq.size(), 0);
    seg(250, 1000, 1, 25, "post_rst");

    // Glitch inside the low phase
    do_reset();
    vq.delete();
    for (int j = 0; j < 800; j++) begin
      @(negedge clk);
      pwm_a = (j < 200);
      if (j == 0) ts[0] = cyc;
    end
    for (int j = 0; j < 800; j++) begin
      @(negedge clk);
      pwm_a = (j < 200) || (j == 400) || (j == 401);
      if (j == 0) ts[1] = cyc;
      if (j == 400) ts[2] = cyc;
    end
    for (int j = 0; j < 250 + LAT; j++) begin
      @(negedge clk);
      pwm_a = (j < 200);
      if (j == 0) ts[3] = cyc;
    end
`ifdef PWM_GLITCH_FILTER_EN
    et = '{ts[1] + LAT, ts[3] + LAT};
    eh = '{200, 200};
    ep = '{800, 800};
    ed = '{25, 25};
`else
    et = '{ts[1] + LAT, ts[2] + LAT, ts[3] + LAT};
    eh = '{200, 200, 2};
    ep = '{800, 400, 400};
    ed = '{25, 50, 0};
`endif
    check("glitch_cnt", vq.size(), et.size());
    for (int k = 0; k < et.size() && k < vq.size(); k++) begin
      check("glitch_t", vq[k].t, et[k]);
      check("glitch_h", vq[k].h, eh[k]);
      check("glitch_p", vq[k].p, ep[k]);
      check("glitch_d", vq[k].d, ed[k]);
    end

    // Timeout with input held high (CNT_W=10)
    do_reset();
    vq10.delete();
    @(negedge clk);
    pwm_b = 1'b1;
    n = cyc;
    repeat (1100) @(negedge clk);
    check("to_hi_cnt", vq10.size(), 1);
    if (vq10.size() > 0) begin
      check("to_hi_t", vq10[0].t, n + TO_LAT);
      check("to_hi_h", vq10[0].h, 0);
      check("to_hi_p", vq10[0].p, 0);
      check("to_hi_d", vq10[0].d, 100);
      check("to_hi_st", vq10[0].st, 1);
    end
    check("stuck_hold", int'(stuck_b), 1);

    // Timeout with input held low after a short pulse
    @(negedge clk);
    pwm_b = 1'b0;
    repeat (5) @(negedge clk);
    vq10.delete();
    for (int j = 0; j < 1100; j++) begin
      @(negedge clk);
      pwm_b = (j < 5);
      if (j == 0) n = cyc;
    end
    check("to_lo_cnt", vq10.size(), 1);
    if (vq10.size() > 0) begin
      check("to_lo_t", vq10[0].t, n + TO_LAT);
      check("to_lo_d", vq10[0].d, 0);
      check("to_lo_st", vq10[0].st, 1);
    end

    // Recovery: two rises clear stuck
    vq10.delete();
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      pwm_b = (j < 100);
      if (j == 0) r0 = cyc;
    end
    check("stuck_pre_rec", int'(stuck_b), 1);
    check("rec_none_yet", vq10.size(), 0);
    for (int j = 0; j < 100 + LAT10 + 20; j++) begin
      @(negedge clk);
      pwm_b = (j < 100);
      if (j == 0) r1 = cyc;
    end
    check("rec_cnt", vq10.size(), 1);
    if (vq10.size() > 0) begin
      check("rec_t", vq10[0].t, r1 + LAT10);
      check("rec_h", vq10[0].h, 100);
      check("rec_p", vq10[0].p, r1 - r0);
      check("rec_d", vq10[0].d, 25);
      check("rec_st", vq10[0].st, 0);
    end
    check("rec_stuck", int'(stuck_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
